// File: rtl/stopwatch_timer.sv
// stopwatch_timer: MM:SS.cc BCD stopwatch / countdown driven by a centisecond
// prescaler, with a first-word-fall-through lap capture FIFO.
module stopwatch_timer #(
  parameter int DVSR      = 1_000_000,
  parameter int LAP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        go,
  input  logic        down,
  input  logic        load,
  input  logic [23:0] preset,
  input  logic        lap,
  input  logic        lap_pop,
  output logic        lap_valid,
  output logic [23:0] lap_data,
  output logic        lap_full,
  output logic        lap_drop,
  output logic        tick,
  output logic        done,
  output logic        wrap,
  output logic [3:0]  d5,
  output logic [3:0]  d4,
  output logic [3:0]  d3,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0
);

  localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(DVSR - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(LAP_DEPTH);

  logic [PW-1:0]     pre_q, pre_d;
  logic [5:0][3:0]   dig_q, dig_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              rip_s;

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic [23:0]       mem_q [LAP_DEPTH];
  logic              lap_drop_q;
  logic              push_ok_s, pop_ok_s;

  // Minutes-tens and seconds-tens stop at 5, every other digit at 9.
  function automatic logic [3:0] digit_max(input logic [2:0] idx);
    if (idx == 3'd3 || idx == 3'd5) begin
      digit_max = 4'd5;
    end else begin
      digit_max = 4'd9;
    end
  endfunction

  function automatic logic [3:0] digit_sat(input logic [3:0] v, input logic [2:0] idx);
    if (v > digit_max(idx)) begin
      digit_sat = digit_max(idx);
    end else begin
      digit_sat = v;
    end
  endfunction

  assign tick = go && (pre_q == PRE_MAX);

  // Prescaler next state: clear/load restart the centisecond period.
  always_comb begin
    pre_d = pre_q;
    if (clr || load) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
    end else if (go) begin
      pre_d = pre_q + PW'(1);
    end else begin
      pre_d = pre_q;
    end
  end

  // Digit next state: ripple carry/borrow from d0 upward; done/wrap only on real ticks.
  always_comb begin
    dig_d  = dig_q;
    done_d = 1'b0;
    wrap_d = 1'b0;
    rip_s  = 1'b1;
    if (clr) begin
      dig_d = '0;
    end else if (load) begin
      for (int i = 0; i < 6; i++) begin
        dig_d[i] = digit_sat(preset[4*i +: 4], 3'(i));
      end
    end else if (tick) begin
      if (!down) begin
        for (int i = 0; i < 6; i++) begin
          if (rip_s) begin
            if (dig_q[i] >= digit_max(3'(i))) begin
              dig_d[i] = 4'd0;
            end else begin
              dig_d[i] = dig_q[i] + 4'd1;
              rip_s    = 1'b0;
            end
          end else begin
            dig_d[i] = dig_q[i];
          end
        end
        wrap_d = rip_s;
      end else if (dig_q != '0) begin
        for (int i = 0; i < 6; i++) begin
          if (rip_s) begin
            if (dig_q[i] == 4'd0) begin
              dig_d[i] = digit_max(3'(i));
            end else begin
              dig_d[i] = dig_q[i] - 4'd1;
              rip_s    = 1'b0;
            end
          end else begin
            dig_d[i] = dig_q[i];
          end
        end
        done_d = (dig_d == '0);
      end else begin
        dig_d = dig_q;
      end
    end else begin
      dig_d = dig_q;
    end
  end

  // Time-keeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      dig_q  <= '0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      dig_q  <= dig_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end

  assign lap_valid = (cnt_q != '0);
  assign lap_full  = (cnt_q == FIFO_FULL);
  assign pop_ok_s  = lap_pop && lap_valid;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign push_ok_s = lap && (!lap_full || pop_ok_s);
  assign lap_data  = lap_valid ? mem_q[rd_ptr_q] : 24'd0;

  // Lap FIFO storage, pointers and drop flag; captures digits before this cycle's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lap_drop_q <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        mem_q[i] <= 24'd0;
      end
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lap_drop_q <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= dig_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      lap_drop_q <= lap && !push_ok_s;
    end
  end

  assign lap_drop = lap_drop_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign d5       = dig_q[5];
  assign d4       = dig_q[4];
  assign d3       = dig_q[3];
  assign d2       = dig_q[2];
  assign d1       = dig_q[1];
  assign d0       = dig_q[0];

endmodule

// File: tb/tb_stopwatch_timer.sv
// Self-checking bench for stopwatch_timer: directed plan plus random stimulus,
// checked against a model that keeps time as a plain centisecond count.
module tb_stopwatch_timer;
  localparam int DVSR      = 4;
  localparam int LAP_DEPTH = 4;
  localparam int TMAX      = 359999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0, go = 1'b0, down = 1'b0, load = 1'b0;
  logic        lap = 1'b0, lap_pop = 1'b0;
  logic [23:0] preset = 24'd0;
  logic        lap_valid, lap_full, lap_drop, tick, done, wrap;
  logic [23:0] lap_data;
  logic [3:0]  d5, d4, d3, d2, d1, d0;

  int errors = 0;
  int checks = 0;
  int m_t = 0, m_pre = 0;
  int q[$];
  bit m_done = 1'b0, m_wrap = 1'b0, m_drop = 1'b0;
  int tick_cnt = 0, done_cnt = 0, wrap_cnt = 0, drop_cnt = 0;

  always #5 clk = ~clk;

  stopwatch_timer #(.DVSR(DVSR), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .go(go), .down(down), .load(load),
    .preset(preset), .lap(lap), .lap_pop(lap_pop), .lap_valid(lap_valid),
    .lap_data(lap_data), .lap_full(lap_full), .lap_drop(lap_drop), .tick(tick),
    .done(done), .wrap(wrap), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0)
  );

  function automatic logic [23:0] to_bcd(input int t);
    int mn, sc, cs;
    mn = t / 6000;
    sc = (t / 100) % 60;
    cs = t % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic int from_preset(input logic [23:0] p);
    int d[6];
    int lim;
    for (int i = 0; i < 6; i++) begin
      lim  = (i == 3 || i == 5) ? 5 : 9;
      d[i] = int'(p[4*i +: 4]);
      if (d[i] > lim) d[i] = lim;
    end
    return ((d[5] * 10 + d[4]) * 60 + d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit  m_tick, pop_ok, push_ok;
    m_tick = go && (m_pre == DVSR - 1);
    if (clr) begin
      q.delete();
      m_drop = 1'b0;
    end else begin
      pop_ok  = lap_pop && (q.size() > 0);
      push_ok = lap && ((q.size() < LAP_DEPTH) || pop_ok);
      m_drop  = lap && !push_ok;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(m_t);
    end
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (clr) begin
      m_t = 0; m_pre = 0;
    end else if (load) begin
      m_t = from_preset(preset); m_pre = 0;
    end else begin
      if (go) m_pre = (m_pre + 1) % DVSR;
      if (m_tick && !down) begin
        if (m_t == TMAX) begin m_t = 0; m_wrap = 1'b1; end
        else m_t = m_t + 1;
      end else if (m_tick && down && m_t > 0) begin
        m_t    = m_t - 1;
        m_done = (m_t == 0);
      end
    end
  endtask

  // One clock: inputs are already driven after a falling edge.
  task automatic cycle();
    #1;
    chk("tick", 24'(tick), 24'(go && (m_pre == DVSR - 1)));
    if (tick) tick_cnt++;
    @(posedge clk);
    model_step();
    #1;
    chk("digits", {d5, d4, d3, d2, d1, d0}, to_bcd(m_t));
    chk("done", 24'(done), 24'(m_done));
    chk("wrap", 24'(wrap), 24'(m_wrap));
    chk("lap_valid", 24'(lap_valid), 24'(q.size() > 0));
    chk("lap_full", 24'(lap_full), 24'(q.size() == LAP_DEPTH));
    chk("lap_drop", 24'(lap_drop), 24'(m_drop));
    chk("lap_data", lap_data, (q.size() > 0) ? to_bcd(q[0]) : 24'd0);
    if (done) done_cnt++;
    if (wrap) wrap_cnt++;
    if (lap_drop) drop_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0; go = 1'b0; down = 1'b0; load = 1'b0; lap = 1'b0; lap_pop = 1'b0;
    #2;
    chk("rst_digits", {d5, d4, d3, d2, d1, d0}, 24'd0);
    chk("rst_flags", 24'({lap_valid, lap_full, lap_drop, tick, done, wrap}), 24'd0);
    chk("rst_lap_data", lap_data, 24'd0);
    m_t = 0; m_pre = 0; q.delete();
    m_done = 1'b0; m_wrap = 1'b0; m_drop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    do_reset();

    // Free run: 40 cycles give 10 ticks.
    go = 1'b1;
    tick_cnt = 0;
    repeat (40) cycle();
    chk("tick_count40", 24'(tick_cnt), 24'd10);
    chk("after40", {d5, d4, d3, d2, d1, d0}, 24'h000010);

    // Up-count wrap from 59:59.99.
    load = 1'b1; preset = 24'h595999; down = 1'b0;
    cycle();
    load = 1'b0; wrap_cnt = 0;
    repeat (6) cycle();
    chk("wrap_once", 24'(wrap_cnt), 24'd1);

    // Countdown from 00:01.00 to zero, then hold.
    load = 1'b1; preset = 24'h000100; down = 1'b1;
    cycle();
    load = 1'b0; done_cnt = 0;
    repeat (DVSR) cycle();
    chk("cd_first", {d5, d4, d3, d2, d1, d0}, 24'h000099);
    repeat (99 * DVSR) cycle();
    chk("cd_zero", {d5, d4, d3, d2, d1, d0}, 24'h000000);
    repeat (10 * DVSR) cycle();
    chk("done_once", 24'(done_cnt), 24'd1);

    // Saturating preset load.
    go = 1'b0; load = 1'b1; preset = 24'h7A9999;
    cycle();
    load = 1'b0;
    chk("sat_load", {d5, d4, d3, d2, d1, d0}, 24'h595999);

    // Five laps without pops: fifth one is dropped, then drain in order.
    go = 1'b1; down = 1'b0; drop_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      lap = 1'b1;
      cycle();
      lap = 1'b0;
      repeat (k + 2) cycle();
    end
    chk("lap_drop_count", 24'(drop_cnt), 24'd1);
    lap_pop = 1'b1;
    repeat (5) cycle();
    lap_pop = 1'b0;
    chk("lap_drained", 24'(lap_valid), 24'd0);

    // clr, load, lap and tick all in one cycle.
    lap = 1'b1;
    repeat (2) cycle();
    lap = 1'b0;
    for (int k = 0; k < DVSR && m_pre != DVSR - 1; k++) cycle();
    clr = 1'b1; load = 1'b1; lap = 1'b1; preset = 24'h123456;
    cycle();
    clr = 1'b0; load = 1'b0; lap = 1'b0;
    chk("clr_digits", {d5, d4, d3, d2, d1, d0}, 24'd0);
    chk("clr_fifo", 24'(lap_valid), 24'd0);
    repeat (6) cycle();
    go = 1'b0; tick_cnt = 0;
    repeat (20) cycle();
    chk("hold_no_tick", 24'(tick_cnt), 24'd0);
    go = 1'b1;
    repeat (4) cycle();

    // Random phase with a mid-run reset.
    for (int n = 0; n < 900; n++) begin
      if (n == 450) do_reset();
      clr     = ($urandom_range(0, 99) == 0);
      load    = ($urandom_range(0, 39) == 0);
      r       = $urandom_range(0, 3);
      preset  = (r == 1) ? 24'h595997 : (r == 2) ? 24'h000002 : 24'($urandom);
      go      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) down = ~down;
      lap     = ($urandom_range(0, 3) == 0);
      lap_pop = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
